// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle control FSM for the 6-bit-PC CPU. It fetches each 10-bit word
//   from the instruction ROM and drives the ROM's pc step (o_done) and branch
//   controls. It sequences the shared-bus register and ALU enables, and it holds
//   the 6-bit link register used by LDPC/BXLR.
//
//   Optional feature: define CU_ILLEGAL_TRAP_EN to trap opcodes 7..15 into
//   HALT. Without it those opcodes execute as NOP and o_halted is tied 0.
//
// Ports
//   i_clk            rising-edge clock
//   i_rst            synchronous active-high reset
//   i_start          1-cycle pulse, leave IDLE and begin fetching
//   i_stop           level, return to IDLE at the next FETCH
//   i_instruction    ROM word at the current pc
//   i_pc_in          ROM pc, valid while o_export_pc=1
//   o_done           pc increment strobe
//   o_branch         load the ROM pc from o_branchaddress
//   o_branchaddress  branch target
//   o_export_pc      ROM drives i_pc_in
//   o_reg_in         one-hot bus->R1..R6 write enable (bit i-1 = Ri)
//   o_reg_out        one-hot R1..R6->bus drive
//   o_ext_out        external data onto bus (LOAD)
//   o_alu_a_in       latch bus into ALU operand A
//   o_alu_g_in       latch ALU result into G
//   o_alu_g_out      drive G onto bus
//   o_alu_op         0=ADD, 1=XOR
//   o_busy           1 in every state except IDLE/HALT
//   o_halted         1 in HALT
//
// States
//   state | meaning
//   IDLE  | waiting for i_start
//   FETCH | latch the instruction into IR, or drop to IDLE on i_stop
//   T1    | first (usually only) execute cycle
//   T2    | ADD/XOR: Ry onto bus, ALU result into G
//   T3    | ADD/XOR: G onto bus, write Rx, step pc
//   HALT  | illegal-opcode trap, left only on reset
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int OP_SIZE  = 4,
  parameter int ARG_SIZE = 3,
  parameter int ARG_NUM  = 2,
  parameter int ADDR_W   = 6
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_start,
  input  logic                                 i_stop,
  input  logic [OP_SIZE+ARG_NUM*ARG_SIZE-1:0]  i_instruction,
  input  logic [ADDR_W-1:0]                    i_pc_in,
  output logic                                 o_done,
  output logic                                 o_branch,
  output logic [ADDR_W-1:0]                    o_branchaddress,
  output logic                                 o_export_pc,
  output logic [5:0]                           o_reg_in,
  output logic [5:0]                           o_reg_out,
  output logic                                 o_ext_out,
  output logic                                 o_alu_a_in,
  output logic                                 o_alu_g_in,
  output logic                                 o_alu_g_out,
  output logic                                 o_alu_op,
  output logic                                 o_busy,
  output logic                                 o_halted
);

  localparam int IW = OP_SIZE + ARG_NUM * ARG_SIZE;

  localparam logic [OP_SIZE-1:0] OP_LOAD = 4'd0;
  localparam logic [OP_SIZE-1:0] OP_MOVE = 4'd1;
  localparam logic [OP_SIZE-1:0] OP_ADD  = 4'd2;
  localparam logic [OP_SIZE-1:0] OP_XOR  = 4'd3;
  localparam logic [OP_SIZE-1:0] OP_BRN  = 4'd4;
  localparam logic [OP_SIZE-1:0] OP_LDPC = 4'd5;
  localparam logic [OP_SIZE-1:0] OP_BXLR = 4'd6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_T1    = 3'd2,
    S_T2    = 3'd3,
    S_T3    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IW-1:0]       r_ir;
  logic [ADDR_W-1:0]   r_lr;

  logic [OP_SIZE-1:0]  w_op;
  logic [ARG_SIZE-1:0] w_rx;
  logic [ARG_SIZE-1:0] w_ry;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_illegal;

  assign w_op      = r_ir[IW-1 -: OP_SIZE];
  assign w_rx      = r_ir[2*ARG_SIZE-1 -: ARG_SIZE];
  assign w_ry      = r_ir[ARG_SIZE-1:0];
  assign w_addr    = r_ir[ADDR_W-1:0];
  assign w_illegal = (w_op > OP_BXLR);

  // Register codes 0 (NA) and 7 (PC) select no bus register.
  function automatic logic [5:0] f_onehot(input logic [ARG_SIZE-1:0] code);
    logic [5:0] v;
    v = 6'b000000;
    case (code)
      3'd1:    v = 6'b000001;
      3'd2:    v = 6'b000010;
      3'd3:    v = 6'b000100;
      3'd4:    v = 6'b001000;
      3'd5:    v = 6'b010000;
      3'd6:    v = 6'b100000;
      default: v = 6'b000000;
    endcase
    return v;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_lr    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && !i_stop) begin
        r_ir <= i_instruction;
      end
      if (r_state == S_T1 && w_op == OP_LDPC) begin
        // A zero literal means "call": link to the word after this LDPC.
        if (w_addr != '0) begin
          r_lr <= w_addr;
        end else begin
          r_lr <= i_pc_in + 6'd1;
        end
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    o_done          = 1'b0;
    o_branch        = 1'b0;
    o_branchaddress = '0;
    o_export_pc     = 1'b0;
    o_reg_in        = 6'b000000;
    o_reg_out       = 6'b000000;
    o_ext_out       = 1'b0;
    o_alu_a_in      = 1'b0;
    o_alu_g_in      = 1'b0;
    o_alu_g_out     = 1'b0;
    o_alu_op        = 1'b0;
    o_busy          = 1'b0;
    o_halted        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_FETCH;
      end

      S_FETCH: begin
        o_busy = 1'b1;
        w_next = i_stop ? S_IDLE : S_T1;
      end

      S_T1: begin
        o_busy = 1'b1;
        w_next = S_FETCH;
        case (w_op)
          OP_LOAD: begin
            o_ext_out = 1'b1;
            o_reg_in  = f_onehot(w_rx);
            o_done    = 1'b1;
          end
          OP_MOVE: begin
            o_reg_out = f_onehot(w_ry);
            o_reg_in  = f_onehot(w_rx);
            o_done    = 1'b1;
          end
          OP_ADD, OP_XOR: begin
            o_reg_out  = f_onehot(w_rx);
            o_alu_a_in = 1'b1;
            w_next     = S_T2;
          end
          OP_BRN: begin
            o_branch        = 1'b1;
            o_branchaddress = w_addr;
          end
          OP_LDPC: begin
            o_export_pc = (w_addr == '0);
            o_done      = 1'b1;
          end
          OP_BXLR: begin
            o_branch        = 1'b1;
            o_branchaddress = r_lr;
          end
          default: begin
`ifdef CU_ILLEGAL_TRAP_EN
            w_next = S_HALT;
`else
            o_done = 1'b1;
`endif
          end
        endcase
      end

      S_T2: begin
        o_busy     = 1'b1;
        o_reg_out  = f_onehot(w_ry);
        o_alu_g_in = 1'b1;
        o_alu_op   = w_op[0];
        w_next     = S_T3;
      end

      S_T3: begin
        o_busy      = 1'b1;
        o_alu_g_out = 1'b1;
        o_reg_in    = f_onehot(w_rx);
        o_done      = 1'b1;
        w_next      = S_FETCH;
      end

      S_HALT: begin
`ifdef CU_ILLEGAL_TRAP_EN
        o_halted = 1'b1;
`endif
        w_next = S_HALT;
      end

      default: w_next = S_IDLE;
    endcase

    // Opcodes 7..15 only matter in T1; this keeps the flag in use in every build.
    if (r_state != S_T1 && w_illegal && r_state == S_HALT) begin
      w_next = S_HALT;
    end
  end

endmodule
